// File: rtl/wptr_full_gen.sv
// rtl/wptr_full_gen.sv - async FIFO write pointer, Gray publish and full flag
// Optional almost-full output enabled by defining WPTR_ALMOST_FULL_EN.
module wptr_full_gen #(
    parameter int ADDR_W = 4
`ifdef WPTR_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH = 2**ADDR_W - 2
`endif
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              winc,
    input  logic [ADDR_W:0]   rptr_gray_sync,
    output logic [ADDR_W-1:0] waddr,
    output logic              wr_en,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              wfull
`ifdef WPTR_ALMOST_FULL_EN
    ,
    output logic              walmost_full
`endif
);

    logic [ADDR_W:0] wbin_q;
    logic [ADDR_W:0] wbin_d;
    logic [ADDR_W:0] wgray_q;
    logic [ADDR_W:0] wgray_d;
    logic [ADDR_W:0] full_match;
    logic            wfull_q;
    logic            wfull_d;

    assign wr_en  = winc & ~wfull_q;
    assign wbin_d = wbin_q + {{ADDR_W{1'b0}}, wr_en};
    assign wgray_d = wbin_d ^ (wbin_d >> 1);

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_match = {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]};
    assign wfull_d    = (wgray_d == full_match);

    assign waddr     = wbin_q[ADDR_W-1:0];
    assign wptr_gray = wgray_q;
    assign wfull     = wfull_q;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            wfull_q <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            wfull_q <= wfull_d;
        end
    end

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [ADDR_W:0] AF_LVL = AF_THRESH[ADDR_W:0];

    logic [ADDR_W:0] rbin_sync;
    logic [ADDR_W:0] level;
    logic            walmost_q;
    logic            walmost_d;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin_sync         = '0;
        rbin_sync[ADDR_W] = rptr_gray_sync[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            rbin_sync[i] = rbin_sync[i+1] ^ rptr_gray_sync[i];
        end
    end

    assign level        = wbin_d - rbin_sync;
    assign walmost_d    = (level >= AF_LVL);
    assign walmost_full = walmost_q;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            walmost_q <= 1'b0;
        end else begin
            walmost_q <= walmost_d;
        end
    end
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// tb/tb_wptr_full_gen.sv - scoreboard bench for wptr_full_gen
// Almost-full checks are active when WPTR_ALMOST_FULL_EN is defined.
module tb_wptr_full_gen;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] rptr_gray_sync;
    logic [3:0] waddr;
    logic       wr_en;
    logic [4:0] wptr_gray;
    logic       wfull;
`ifdef WPTR_ALMOST_FULL_EN
    logic       walmost_full;
`endif

    wptr_full_gen #(
        .ADDR_W(4)
`ifdef WPTR_ALMOST_FULL_EN
        ,
        .AF_THRESH(14)
`endif
    ) dut (
        .wclk(wclk),
        .wrst_n(wrst_n),
        .winc(winc),
        .rptr_gray_sync(rptr_gray_sync),
        .waddr(waddr),
        .wr_en(wr_en),
        .wptr_gray(wptr_gray),
        .wfull(wfull)
`ifdef WPTR_ALMOST_FULL_EN
        ,
        .walmost_full(walmost_full)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        bit         chk;
        bit         step_ok;
        logic [3:0] waddr;
        bit         wr_en;
        logic [4:0] gray;
        bit         full;
        bit         af;
        int         tag;
    } rec_t;

    rec_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   phase = 0;

    int   m_bin = 0;
    bit   m_full = 0;
    bit   m_af = 0;
    bit   m_known = 0;
    bit   m_prev_rst = 0;

    function automatic logic [4:0] to_gray(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    task automatic cmp(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s phase=%0d actual=%0h required=%0h", nm, tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge and queue what the DUT should show.
    task automatic drive(input bit rst_v, input bit winc_v, input int rb);
        rec_t r;
        bit   we;
        int   lvl;
        @(posedge wclk);
        #1;
        wrst_n         = rst_v;
        winc           = winc_v;
        rptr_gray_sync = to_gray(rb);
        we             = winc_v & ~m_full;
        r.chk     = m_known;
        r.step_ok = m_known && !m_prev_rst;
        r.waddr   = m_bin[3:0];
        r.wr_en   = we;
        r.gray    = to_gray(m_bin);
        r.full    = m_full;
        r.af      = m_af;
        r.tag     = phase;
        q.push_back(r);
        if (!rst_v) begin
            m_bin      = 0;
            m_full     = 0;
            m_af       = 0;
            m_known    = 1;
            m_prev_rst = 1;
        end else begin
            m_bin      = (m_bin + int'(we)) & 31;
            lvl        = (m_bin - rb) & 31;
            m_full     = (lvl == 16);
            m_af       = (lvl >= 14);
            m_prev_rst = 0;
        end
    endtask

    // Monitor: pops one expectation per cycle, sampled on the falling edge.
    initial begin
        rec_t       r;
        logic [4:0] prev_gray;
        bit         prev_ok;
        prev_ok = 0;
        prev_gray = '0;
        forever begin
            @(negedge wclk);
            if (q.size() > 0) begin
                r = q.pop_front();
                if (r.chk) begin
                    cmp("waddr", r.tag, 32'(waddr), 32'(r.waddr));
                    cmp("wr_en", r.tag, 32'(wr_en), 32'(r.wr_en));
                    cmp("wptr_gray", r.tag, 32'(wptr_gray), 32'(r.gray));
                    cmp("wfull", r.tag, 32'(wfull), 32'(r.full));
`ifdef WPTR_ALMOST_FULL_EN
                    cmp("walmost_full", r.tag, 32'(walmost_full), 32'(r.af));
`endif
                    if (r.step_ok && prev_ok && (wptr_gray !== prev_gray)) begin
                        cmp("gray_one_bit_step", r.tag, 32'($countones(wptr_gray ^ prev_gray)), 32'd1);
                    end
                    prev_gray = wptr_gray;
                    prev_ok   = 1;
                end
            end
        end
    end

    initial begin
        int acc;
        wrst_n = 1'b1;
        winc = 1'b0;
        rptr_gray_sync = '0;

        phase = 1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        for (int i = 0; i < 16; i++) drive(1, 1, 0);

        phase = 2;
        for (int i = 0; i < 4; i++) drive(1, 1, 0);

        phase = 3;
        drive(1, 0, 1);
        drive(1, 1, 1);
        drive(1, 0, 1);

        phase = 4;
        acc = 0;
        for (int k = 0; k < 80 && acc < 64; k++) begin
            if (!m_full) acc++;
            drive(1, 1, m_bin);
        end
        drive(1, 0, m_bin);
        if (acc != 64) begin
            n_err++;
            $display("FAIL wrap_write_count actual=%0d required=64", acc);
        end

        phase = 5;
        drive(0, 0, 0);
        for (int i = 0; i < 7; i++) drive(1, 1, 0);
        drive(0, 1, 0);
        drive(1, 1, 0);
        drive(1, 0, 0);

        phase = 6;
        drive(0, 0, 0);
        for (int i = 0; i < 15; i++) drive(1, 1, 0);
        drive(1, 1, 1);
        drive(1, 1, 1);
        drive(1, 0, 1);

        phase = 7;
        drive(0, 0, 0);
        for (int i = 0; i < 15; i++) drive(1, 1, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge wclk);
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
